// File: rtl/sym_conv_mac.sv
// rtl/sym_conv_mac.sv - time-multiplexed 2-D convolution MAC for doubly symmetric KxK kernels
// Optional round-half-up before the normalisation shift: define CONV_ROUND_EN.
module sym_conv_mac #(
  parameter int K      = 11,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 18,
  parameter int SHIFT  = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   coef_we,
  input  logic [$clog2(((K+1)/2)*((K+1)/2))-1:0] coef_addr,
  input  logic [COEF_W-1:0]                      coef_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [K*K*PIX_W-1:0]                   in_win,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [OUT_W-1:0]                       dout,
  output logic                                   sat
);

  localparam int H     = (K + 1) / 2;
  localparam int RW    = $clog2(H);
  localparam int FW    = PIX_W + 2;
  localparam int ACC_W = PIX_W + COEF_W + 2 * $clog2(K);
  localparam int VW    = (ACC_W + 1 > OUT_W + 1) ? ACC_W + 1 : OUT_W + 1;

`ifdef CONV_ROUND_EN
  localparam logic [VW-1:0] RND = (SHIFT > 0) ? (VW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
  localparam logic [VW-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  state_t               state_q, state_d;
  logic                 rdy_q;
  logic [K*K*PIX_W-1:0] win_q, win_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [RW-1:0]        r_q, r_d;
  logic [OUT_W-1:0]     dout_q, dout_d;
  logic                 sat_q, sat_d;
  logic [COEF_W-1:0]    coef_q [H*H];

  logic [FW-1:0]        fold [H];
  logic [ACC_W-1:0]     row_sum;
  logic [VW-1:0]        v;
  logic                 accept;

  // Fold the up-to-four mirror images of each quadrant pixel in row r, then weight them.
  always_comb begin
    int r;
    int rm;
    r       = int'(r_q);
    rm      = K - 1 - r;
    row_sum = '0;
    for (int c = 0; c < H; c++) begin
      fold[c] = FW'(win_q[(K*K-1-(r*K+c))*PIX_W +: PIX_W]);
      if (rm != r)
        fold[c] = fold[c] + FW'(win_q[(K*K-1-(rm*K+c))*PIX_W +: PIX_W]);
      if (K - 1 - c != c)
        fold[c] = fold[c] + FW'(win_q[(K*K-1-(r*K+K-1-c))*PIX_W +: PIX_W]);
      if (rm != r && K - 1 - c != c)
        fold[c] = fold[c] + FW'(win_q[(K*K-1-(rm*K+K-1-c))*PIX_W +: PIX_W]);
      row_sum = row_sum + ACC_W'(fold[c]) * ACC_W'(coef_q[r*H+c]);
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    acc_d    = acc_q;
    r_d      = r_q;
    dout_d   = dout_q;
    sat_d    = sat_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = rdy_q;
      S_OUT:   in_ready = rdy_q & out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;
    v      = (VW'(acc_q) + VW'(row_sum) + RND) >> SHIFT;

    case (state_q)
      S_IDLE: ;
      S_ACC: begin
        acc_d = acc_q + row_sum;
        if (r_q == RW'(H - 1)) begin
          r_d     = '0;
          state_d = S_OUT;
          sat_d   = (v >> OUT_W) != '0;
          dout_d  = sat_d ? '1 : v[OUT_W-1:0];
        end else begin
          r_d = r_q + RW'(1);
        end
      end
      S_OUT: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Acceptance only happens in IDLE or on the OUT handshake edge; both restart accumulation.
    if (accept) begin
      win_d   = in_win;
      acc_d   = '0;
      r_d     = '0;
      state_d = S_ACC;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      win_q   <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      dout_q  <= '0;
      sat_q   <= 1'b0;
      for (int i = 0; i < H*H; i++) coef_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      win_q   <= win_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      dout_q  <= dout_d;
      sat_q   <= sat_d;
      if (coef_we && state_q == S_IDLE && int'(coef_addr) < H*H)
        coef_q[coef_addr] <= coef_data;
    end
  end

  assign out_valid = (state_q == S_OUT);
  assign dout      = dout_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_sym_conv_mac.sv
// tb/tb_sym_conv_mac.sv - scoreboard bench for sym_conv_mac (SHIFT=0 and SHIFT=4 instances)
`timescale 1ns/1ps
module tb_sym_conv_mac;
  localparam int K      = 11;
  localparam int H      = (K + 1) / 2;
  localparam int PIX_W  = 8;
  localparam int COEF_W = 8;
  localparam int OUT_W  = 18;
  localparam int AW     = $clog2(H*H);
  localparam int WW     = K*K*PIX_W;
  localparam longint MAXO = (longint'(1) << OUT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              in_valid;
  logic [WW-1:0]     in_win;
  logic              out_ready;
  logic              in_ready, out_valid, sat;
  logic [OUT_W-1:0]  dout;
  logic              in_ready4, out_valid4, sat4;
  logic [OUT_W-1:0]  dout4;

  sym_conv_mac #(.K(K), .PIX_W(PIX_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .SHIFT(0)) u_dut (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .sat(sat));

  sym_conv_mac #(.K(K), .PIX_W(PIX_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .SHIFT(4)) u_dut_s4 (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .in_valid(in_valid), .in_ready(in_ready4), .in_win(in_win),
    .out_valid(out_valid4), .out_ready(out_ready), .dout(dout4), .sat(sat4));

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int qm [H*H];
  longint exp_q[$];
  int     acc_cyc_q[$];
  bit     ov_prev = 1'b0;

  int quad [H*H] = '{
    'h00, 'h00, 'h01, 'h01, 'h02, 'h02,
    'h00, 'h01, 'h02, 'h03, 'h05, 'h06,
    'h01, 'h02, 'h04, 'h08, 'h0c, 'h0d,
    'h01, 'h03, 'h08, 'h0f, 'h16, 'h19,
    'h02, 'h05, 'h0c, 'h16, 'h20, 'h24,
    'h02, 'h06, 'h0d, 'h19, 'h24, 'h29};

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [WW-1:0] fill(input logic [7:0] val);
    logic [WW-1:0] w;
    for (int p = 0; p < K*K; p++) w[p*PIX_W +: PIX_W] = val;
    return w;
  endfunction

  function automatic logic [WW-1:0] set_pix(input logic [WW-1:0] w, input int i, input int j,
                                            input logic [7:0] val);
    logic [WW-1:0] r;
    r = w;
    r[(K*K-1-(i*K+j))*PIX_W +: PIX_W] = val;
    return r;
  endfunction

  // Reference: full KxK weighted sum with mirrored weights, no folding.
  function automatic longint model_acc(input logic [WW-1:0] w);
    longint s;
    int qi, qj;
    s = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        qi = (i < K-1-i) ? i : K-1-i;
        qj = (j < K-1-j) ? j : K-1-j;
        s += longint'(w[(K*K-1-(i*K+j))*PIX_W +: PIX_W]) * longint'(qm[qi*H+qj]);
      end
    return s;
  endfunction

  function automatic longint scale(input longint a, input int sh);
    longint r;
    r = 0;
`ifdef CONV_ROUND_EN
    if (sh > 0) r = longint'(1) << (sh - 1);
`endif
    return (a + r) >> sh;
  endfunction

  function automatic longint clip(input longint v);
    return (v > MAXO) ? MAXO : v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    longint a;
    if (rst) begin
      if (out_valid && !ov_prev) begin
        if (acc_cyc_q.size() == 0) chk("spurious_out_valid", 1, 0);
        else chk("latency", cyc - acc_cyc_q.pop_front(), H);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          a = exp_q.pop_front();
          chk("dout", longint'(dout), clip(scale(a, 0)));
          chk("sat", longint'(sat), longint'(scale(a, 0) > MAXO));
          chk("dout_s4", longint'(dout4), clip(scale(a, 4)));
          chk("sat_s4", longint'(sat4), longint'(scale(a, 4) > MAXO));
          chk("out_valid_s4", longint'(out_valid4), 1);
        end
      end
    end
    ov_prev = out_valid;
  end

  task automatic write_coef(input int addr, input logic [7:0] data, input bit upd);
    coef_we   = 1'b1;
    coef_addr = AW'(addr);
    coef_data = data;
    @(posedge clk); #1;
    coef_we = 1'b0;
    if (upd) qm[addr] = int'(data);
  endtask

  task automatic load_all(input logic [7:0] val);
    for (int i = 0; i < H*H; i++) write_coef(i, val, 1'b1);
  endtask

  task automatic offer(input logic [WW-1:0] w);
    int n;
    n        = 0;
    in_win   = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else begin
      exp_q.push_back(model_acc(w));
      acc_cyc_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) chk("drain_timeout", longint'(exp_q.size()), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    longint e;
    rst = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    in_valid = 1'b0; in_win = '0; out_ready = 1'b1;
    for (int i = 0; i < H*H; i++) qm[i] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_dout", longint'(dout), 0);
    chk("rst_sat", longint'(sat), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rdy_before_first_edge", longint'(in_ready), 0);
    @(posedge clk); #1;
    chk("rdy_after_first_edge", longint'(in_ready), 1);

    load_all(8'h01);
    offer(fill(8'h11));
    drain();

    for (int i = 0; i < H*H; i++) write_coef(i, quad[i][7:0], 1'b1);
    offer(fill(8'h11));
    offer(set_pix(fill(8'h00), H-1, H-1, 8'hFF));
    offer(set_pix(fill(8'h00), 0, 0, 8'hFF));
    drain();

    load_all(8'hFF);
    offer(fill(8'hFF));
    drain();

    for (int t = 0; t < 2; t++) begin
      logic [WW-1:0] w;
      for (int i = 0; i < H*H; i++) write_coef(i, 8'($urandom_range(0, 255)), 1'b1);
      for (int p = 0; p < K*K; p++) w[p*PIX_W +: PIX_W] = 8'($urandom_range(0, 255));
      offer(w);
      drain();
    end

    // Back-pressure: result must hold while out_ready is low.
    load_all(8'h01);
    out_ready = 1'b0;
    offer(fill(8'h11));
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    e = clip(scale(exp_q[0], 0));
    repeat (10) begin
      @(negedge clk);
      chk("hold_dout", longint'(dout), e);
      chk("hold_in_ready", longint'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Coefficient write during ACC is dropped.
    offer(fill(8'h11));
    write_coef(0, 8'h05, 1'b0);
    drain();
    offer(fill(8'h11));
    drain();

    // Reset mid-accumulation aborts the window and clears coefficients.
    offer(fill(8'h11));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    acc_cyc_q.delete();
    for (int i = 0; i < H*H; i++) qm[i] = 0;
    #1;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_in_ready", longint'(in_ready), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_hold_out_valid", longint'(out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    offer(fill(8'h11));
    drain();
    load_all(8'h01);
    offer(fill(8'h11));
    drain();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sym_conv_mac.md
# sym_conv_mac

- Parametrised, time-multiplexed 2-D convolution engine for K×K kernels that are symmetric about both axes, as used by the Gaussian scale-space stage.
- Accepts one flattened K×K pixel window per handshake and holds only the H×H coefficient quadrant (H=(K+1)/2) in a run-time writable register file.
- Folds mirrored pixels and accumulates one folded row per cycle, then rounds, shifts and saturates the result.
- Replaces the fixed 11×11, multi-clock convolver with a single-clock, back-pressured, width/size-generic block.

## Interface
- K, 11, kernel size; odd, 3..15; H=(K+1)/2
- PIX_W, 8, unsigned pixel width
- COEF_W, 8, unsigned coefficient width
- OUT_W, 18, output width
- SHIFT, 0, normalisation right shift, 0..ACC_W-1
- ACC_W (localparam), PIX_W+COEF_W+2*$clog2(K), accumulator width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(H*H)  quadrant index i*H+j, i,j in 0..H-1
- coef_data  in  COEF_W  coefficient value
- in_valid  in  1  window valid
- in_ready  out  1  window accepted when in_valid&in_ready
- in_win  in  K*K*PIX_W  row-major window; pixel (i,j) at [(K*K-1-(i*K+j))*PIX_W +: PIX_W], so (0,0) is at the MSBs
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&out_ready
- dout  out  OUT_W  convolution result
- sat  out  1  dout was clipped; qualified by out_valid

## Operation
- Effective weight w(i,j)=q[min(i,K-1-i)][min(j,K-1-j)].
- Folded pixel f(r,c) for r,c<H is the sum of the distinct pixels among (r,c), (K-1-r,c), (r,K-1-c), (K-1-r,K-1-c).
  - Centre row and centre column are not doubled.
  - Width is PIX_W+2.
- States:
  - IDLE: in_ready=1. On acceptance, register in_win, clear acc, set r=0, go to ACC.
  - ACC: each cycle, acc += sum over c of f(r,c)*q[r][c]; r++. After the r=H-1 cycle, go to OUT.
  - OUT: out_valid=1, dout and sat held stable. On out_ready, go to ACC if a new window is accepted in the same cycle, else go to IDLE.
- in_ready = rdy_q & (IDLE | (OUT & out_ready)).
  - rdy_q is a flop reset to 0 and set on the first edge after rst deasserts.
- Final value v = (acc_final + RND) >> SHIFT.
  - If v > 2^OUT_W-1: dout = all ones and sat=1; otherwise dout=v and sat=0.
- Coefficient writes are applied at the clock edge only in IDLE. Writes in ACC or OUT are dropped.
- No arithmetic overflows internally; ACC_W covers the worst case.

## Timing
- Acceptance edge E0. Accumulation edges are E1..EH.
- dout, sat and out_valid are registered at EH, so out_valid rises H cycles after acceptance.
- Back-to-back throughput is one window per H+1 cycles.
- dout and sat are stable from out_valid rise until the handshake.
- Reset values: in_ready=0, out_valid=0, dout=0, sat=0, state=IDLE, all q=0, acc=0.
- Reset mid-operation aborts immediately. The in-flight window is lost and no result is emitted.
- Simultaneous out_ready and in_valid in OUT: the result is consumed and the new window is accepted on the same edge.

## Configuration
- CONV_ROUND_EN defined: RND=2^(SHIFT-1) when SHIFT>0 (round half up).
- CONV_ROUND_EN undefined: RND=0 (truncate).
- SHIFT=0 gives identical results either way.

## Test plan
- Default parameters, all q=1, all pixels 0x11 -> dout=0x809, sat=0, out_valid 6 cycles after accept.
- Quadrant rows 00_00_01_01_02_02 / 00_01_02_03_05_06 / 01_02_04_08_0c_0d / 01_03_08_0f_16_19 / 02_05_0c_16_20_24 / 02_06_0d_19_24_29 with all pixels 0x11 -> dout=0x4411. Same coefficients, only centre pixel 0xFF -> 0x28D7; only pixel (0,0) 0xFF -> 0.
- All q=0xFF, all pixels 0xFF -> dout=0x3FFFF, sat=1.
- SHIFT=4, all q=1, pixels 0x11 -> dout=0x81 with CONV_ROUND_EN, 0x80 without.
- out_ready low for 10 cycles -> dout stable, in_ready=0. Coefficient write issued during ACC is dropped and the next window uses the old value. out_ready and in_valid asserted together -> next out_valid 6 cycles later.
- rst asserted at E3 -> out_valid=0, in_ready=0, q cleared. After release, reload q=1 and feed the all-0x11 window -> dout=0x809.
